// File: rtl/sent_tx_scheduler.sv
// SENT transmit frame sequencer: pulls fast-channel words from the TX FIFO, builds the status
// nibble with the streamed serial message bits, and hands one frame at a time to the encoder.
module sent_tx_scheduler #(
    parameter int         DATAWIDTH  = 12,
    parameter logic [1:0] STATUS_APP = 2'b00,
    parameter int         SHORT_LEN  = 16,
    parameter int         ENH_LEN    = 18
) (
    input  logic                 clk_tx,
    input  logic                 reset_tx,
    input  logic                 enable,
    input  logic                 channel_format,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    input  logic [DATAWIDTH-1:0] fifo_rdata,
    input  logic                 msg_valid,
    input  logic [17:0]          msg_bit2,
    input  logic [17:0]          msg_bit3,
    output logic                 msg_ready,
    output logic                 frame_valid,
    input  logic                 enc_ready,
    output logic [DATAWIDTH-1:0] frame_data,
    output logic [3:0]           frame_status,
    input  logic                 frame_done,
    output logic                 stale_data,
    output logic                 msg_done
);

    localparam int IDXW = 5;
    localparam logic [IDXW-1:0] SHORT_LAST = IDXW'(SHORT_LEN - 1);
    localparam logic [IDXW-1:0] ENH_LAST   = IDXW'(ENH_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_RD,
        S_ISSUE,
        S_WAIT_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [DATAWIDTH-1:0] r_data;
    logic                 r_stale;
    logic                 r_msg_active;
    logic [IDXW-1:0]      r_idx;
    logic [IDXW-1:0]      r_last_idx;
    logic [17:0]          r_bit2;
    logic [17:0]          r_bit3;
    logic                 r_msg_done;

    logic                 w_rd_en;
    logic                 w_msg_ready;
    logic                 w_frame_valid;
    logic                 w_msg_load;
    logic                 w_frame_end;
    logic [1:0]           w_serial;

    always_ff @(posedge clk_tx or posedge reset_tx) begin
        if (reset_tx) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_rd_en       = 1'b0;
        w_msg_ready   = 1'b0;
        w_frame_valid = 1'b0;
        w_frame_end   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                w_msg_ready = !r_msg_active;
                // An empty FIFO skips the read and re-sends the held word.
                if (fifo_empty) begin
                    w_state_next = S_ISSUE;
                end else begin
                    w_rd_en      = 1'b1;
                    w_state_next = S_WAIT_RD;
                end
            end
            S_WAIT_RD: begin
                w_state_next = S_ISSUE;
            end
            S_ISSUE: begin
                w_frame_valid = 1'b1;
                if (enc_ready) begin
                    w_state_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (frame_done) begin
                    w_frame_end  = 1'b1;
                    w_state_next = enable ? S_FETCH : S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_msg_load = w_msg_ready && msg_valid;

    always_ff @(posedge clk_tx or posedge reset_tx) begin
        if (reset_tx) begin
            r_data       <= '0;
            r_stale      <= 1'b0;
            r_msg_active <= 1'b0;
            r_idx        <= '0;
            r_last_idx   <= '0;
            r_bit2       <= '0;
            r_bit3       <= '0;
            r_msg_done   <= 1'b0;
        end else begin
            r_msg_done <= 1'b0;

            if (r_state == S_FETCH && fifo_empty) begin
                r_stale <= 1'b1;
            end
            if (r_state == S_WAIT_RD) begin
                r_data  <= fifo_rdata;
                r_stale <= 1'b0;
            end

            if (w_msg_load) begin
                r_msg_active <= 1'b1;
                r_bit2       <= msg_bit2;
                r_bit3       <= msg_bit3;
                r_last_idx   <= channel_format ? ENH_LAST : SHORT_LAST;
                r_idx        <= '0;
            end else if (w_frame_end) begin
                // Stopping mid-message abandons it silently; the next run starts a fresh one.
                if (!enable) begin
                    r_msg_active <= 1'b0;
                    r_idx        <= '0;
                end else if (r_msg_active) begin
                    if (r_idx == r_last_idx) begin
                        r_msg_done   <= 1'b1;
                        r_msg_active <= 1'b0;
                        r_idx        <= '0;
                    end else begin
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
            end
        end
    end

    assign w_serial     = r_msg_active ? {r_bit3[r_idx], r_bit2[r_idx]} : 2'b00;

    assign fifo_rd_en   = w_rd_en;
    assign msg_ready    = w_msg_ready;
    assign frame_valid  = w_frame_valid;
    assign frame_data   = r_data;
    assign frame_status = {w_serial, STATUS_APP};
    assign stale_data   = r_stale;
    assign msg_done     = r_msg_done;

endmodule

// File: tb/tb_sent_tx_scheduler.sv
// Bench for sent_tx_scheduler: FIFO and encoder models plus a frame scoreboard.
module tb_sent_tx_scheduler;

    localparam int DW = 12;

    logic          clk_tx = 1'b0;
    logic          reset_tx = 1'b1;
    logic          enable = 1'b0;
    logic          channel_format = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rdata = '0;
    logic          msg_valid = 1'b0;
    logic [17:0]   msg_bit2 = '0;
    logic [17:0]   msg_bit3 = '0;
    logic          msg_ready;
    logic          frame_valid;
    logic          enc_ready = 1'b1;
    logic [DW-1:0] frame_data;
    logic [3:0]    frame_status;
    logic          frame_done = 1'b0;
    logic          stale_data;
    logic          msg_done;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [3:0]    status;
        logic          stale;
    } frame_t;

    frame_t        exp_q[$];
    logic [DW-1:0] fifo_q[$];

    int errors = 0;
    int checks = 0;
    int frames_seen = 0;
    int done_cnt = 0;
    int rd_count = 0;
    int rd_on_empty = 0;
    int msg_done_cnt = 0;
    int msg_done_frames = 0;
    bit ready_at_done = 1'b0;

    sent_tx_scheduler #(
        .DATAWIDTH (DW),
        .STATUS_APP(2'b00),
        .SHORT_LEN (16),
        .ENH_LEN   (18)
    ) dut (
        .clk_tx        (clk_tx),
        .reset_tx      (reset_tx),
        .enable        (enable),
        .channel_format(channel_format),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rdata    (fifo_rdata),
        .msg_valid     (msg_valid),
        .msg_bit2      (msg_bit2),
        .msg_bit3      (msg_bit3),
        .msg_ready     (msg_ready),
        .frame_valid   (frame_valid),
        .enc_ready     (enc_ready),
        .frame_data    (frame_data),
        .frame_status  (frame_status),
        .frame_done    (frame_done),
        .stale_data    (stale_data),
        .msg_done      (msg_done)
    );

    always #5 clk_tx = ~clk_tx;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [DW-1:0] d, input logic [3:0] s, input logic st);
        frame_t f;
        f.data   = d;
        f.status = s;
        f.stale  = st;
        exp_q.push_back(f);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_tx);
    endtask

    task automatic wait_frames(input int target);
        int budget = 0;
        while (frames_seen < target && budget < 600) begin
            @(negedge clk_tx);
            budget++;
        end
        if (frames_seen < target) check_val("frame_timeout", frames_seen, target);
    endtask

    task automatic wait_valid();
        int budget = 0;
        while (!frame_valid && budget < 50) begin
            @(negedge clk_tx);
            budget++;
        end
        if (!frame_valid) check_val("valid_timeout", frame_valid, 1);
    endtask

    task automatic wait_quiet();
        int budget = 0;
        while ((done_cnt != 0 || frame_done || frame_valid) && budget < 100) begin
            @(negedge clk_tx);
            budget++;
        end
        tick(3);
    endtask

    // FIFO model: registered read data, valid the cycle after the read pulse.
    always @(posedge clk_tx) begin
        if (fifo_rd_en) begin
            rd_count++;
            if (fifo_q.size() == 0) rd_on_empty++;
            else fifo_rdata <= fifo_q.pop_front();
        end
    end

    always @(negedge clk_tx) fifo_empty = (fifo_q.size() == 0);

    // Encoder model: compares each accepted frame, then reports completion 5 cycles later.
    always @(negedge clk_tx) begin
        frame_t e;
        frame_done = 1'b0;
        if (done_cnt != 0) begin
            done_cnt--;
            if (done_cnt == 0) frame_done = 1'b1;
        end
        if (frame_valid && enc_ready) begin
            frames_seen++;
            $display("frame %0d: data=0x%03h status=%b stale=%b", frames_seen, frame_data, frame_status, stale_data);
            if (exp_q.size() == 0) begin
                check_val("unexpected_frame", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check_val("frame_data", frame_data, e.data);
                check_val("frame_status", frame_status, e.status);
                check_val("stale_data", stale_data, e.stale);
            end
            done_cnt = 5;
        end
    end

    always @(negedge clk_tx) begin
        if (msg_done) begin
            msg_done_cnt++;
            msg_done_frames = frames_seen;
            ready_at_done   = msg_ready;
        end
    end

    initial begin
        int base;
        int rd0;
        int rd1;
        int md0;

        // Reset state
        tick(3);
        check_val("rst_frame_valid", frame_valid, 0);
        check_val("rst_fifo_rd_en", fifo_rd_en, 0);
        check_val("rst_msg_ready", msg_ready, 0);
        check_val("rst_frame_data", frame_data, 0);
        check_val("rst_frame_status", frame_status, 0);
        check_val("rst_stale", stale_data, 0);
        check_val("rst_msg_done", msg_done, 0);
        reset_tx = 1'b0;
        tick(2);
        check_val("idle_frame_valid", frame_valid, 0);

        // Two FIFO words, latency from enable
        fifo_q.push_back(12'h001);
        fifo_q.push_back(12'h002);
        push_exp(12'h001, 4'h0, 1'b0);
        push_exp(12'h002, 4'h0, 1'b0);
        tick(2);
        base = frames_seen;
        rd0  = rd_count;
        enable = 1'b1;
        @(negedge clk_tx);
        check_val("lat_rd_en_c1", fifo_rd_en, 1);
        check_val("lat_valid_c1", frame_valid, 0);
        @(negedge clk_tx);
        check_val("lat_valid_c2", frame_valid, 0);
        @(negedge clk_tx);
        check_val("lat_valid_c3", frame_valid, 1);
        wait_frames(base + 2);
        enable = 1'b0;
        wait_quiet();
        check_val("t1_reads", rd_count - rd0, 2);

        // Single word, then stale repeats
        fifo_q.push_back(12'h00A);
        push_exp(12'h00A, 4'h0, 1'b0);
        push_exp(12'h00A, 4'h0, 1'b1);
        push_exp(12'h00A, 4'h0, 1'b1);
        tick(2);
        base = frames_seen;
        rd0  = rd_count;
        enable = 1'b1;
        wait_frames(base + 3);
        enable = 1'b0;
        wait_quiet();
        check_val("t2_reads", rd_count - rd0, 1);

        // Enhanced serial message, format flipped mid-message
        channel_format = 1'b1;
        msg_bit3 = 18'h00001;
        msg_bit2 = 18'h2AAAA;
        for (int k = 0; k < 18; k++) push_exp(12'h00A, {msg_bit3[k], msg_bit2[k], 2'b00}, 1'b1);
        push_exp(12'h00A, 4'h0, 1'b1);
        base = frames_seen;
        md0  = msg_done_cnt;
        msg_valid = 1'b1;
        enable = 1'b1;
        @(negedge clk_tx);
        check_val("t3_msg_ready_fetch", msg_ready, 1);
        @(negedge clk_tx);
        msg_valid = 1'b0;
        wait_frames(base + 5);
        channel_format = 1'b0;
        wait_frames(base + 19);
        enable = 1'b0;
        wait_quiet();
        check_val("t3_msg_done_count", msg_done_cnt - md0, 1);
        check_val("t3_msg_done_after", msg_done_frames - base, 18);
        check_val("t3_ready_after_done", ready_at_done, 1);

        // Short serial message, next message accepted at frame 16
        channel_format = 1'b0;
        msg_bit3 = 18'h00001;
        msg_bit2 = 18'h0F0F3;
        for (int k = 0; k < 16; k++) push_exp(12'h00A, {msg_bit3[k], msg_bit2[k], 2'b00}, 1'b1);
        push_exp(12'h00A, {msg_bit3[0], msg_bit2[0], 2'b00}, 1'b1);
        base = frames_seen;
        md0  = msg_done_cnt;
        msg_valid = 1'b1;
        enable = 1'b1;
        wait_frames(base + 17);
        enable = 1'b0;
        msg_valid = 1'b0;
        wait_quiet();
        check_val("t4_msg_done_count", msg_done_cnt - md0, 1);
        check_val("t4_msg_done_after", msg_done_frames - base, 16);

        // Encoder stall
        fifo_q.push_back(12'h123);
        enc_ready = 1'b0;
        tick(2);
        base = frames_seen;
        rd0  = rd_count;
        enable = 1'b1;
        wait_valid();
        rd1 = rd_count;
        fifo_q.push_back(12'h456);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_tx);
            check_val("stall_valid", frame_valid, 1);
            check_val("stall_data", frame_data, 12'h123);
            check_val("stall_status", frame_status, 4'h0);
        end
        check_val("stall_first_read", rd1 - rd0, 1);
        check_val("stall_no_extra_read", rd_count, rd1);
        push_exp(12'h123, 4'h0, 1'b0);
        enc_ready = 1'b1;
        wait_frames(base + 1);
        enable = 1'b0;
        wait_quiet();

        // Enable dropped during frame 5 of an enhanced message
        channel_format = 1'b1;
        msg_bit3 = 18'h00020;
        msg_bit2 = 18'h00040;
        push_exp(12'h456, {msg_bit3[0], msg_bit2[0], 2'b00}, 1'b0);
        for (int k = 1; k < 6; k++) push_exp(12'h456, {msg_bit3[k], msg_bit2[k], 2'b00}, 1'b1);
        base = frames_seen;
        md0  = msg_done_cnt;
        msg_valid = 1'b1;
        enable = 1'b1;
        wait_frames(base + 6);
        enable = 1'b0;
        wait_quiet();
        check_val("abort_no_msg_done", msg_done_cnt - md0, 0);
        check_val("abort_idle_valid", frame_valid, 0);
        msg_bit3 = 18'h00001;
        msg_bit2 = 18'h00002;
        push_exp(12'h456, 4'b1000, 1'b1);
        push_exp(12'h456, 4'b0100, 1'b1);
        base = frames_seen;
        enable = 1'b1;
        wait_frames(base + 2);
        enable = 1'b0;
        msg_valid = 1'b0;
        wait_quiet();
        check_val("abort2_no_msg_done", msg_done_cnt - md0, 0);

        // Asynchronous reset while in ISSUE
        enc_ready = 1'b0;
        enable = 1'b1;
        wait_valid();
        check_val("pre_rst_data", frame_data, 12'h456);
        reset_tx = 1'b1;
        #1;
        check_val("arst_frame_valid", frame_valid, 0);
        check_val("arst_frame_data", frame_data, 0);
        check_val("arst_frame_status", frame_status, 0);
        check_val("arst_stale", stale_data, 0);
        check_val("arst_rd_en", fifo_rd_en, 0);
        check_val("arst_msg_ready", msg_ready, 0);
        check_val("arst_msg_done", msg_done, 0);
        enable = 1'b0;
        tick(2);
        reset_tx = 1'b0;
        tick(2);
        check_val("post_rst_idle", frame_valid, 0);
        enc_ready = 1'b1;
        push_exp(12'h000, 4'h0, 1'b1);
        base = frames_seen;
        enable = 1'b1;
        wait_frames(base + 1);
        enable = 1'b0;
        wait_quiet();

        check_val("scoreboard_drained", exp_q.size(), 0);
        check_val("read_while_empty", rd_on_empty, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sent_tx_scheduler.md
Name: sent_tx_scheduler

Overview:
- Frame-level sequencer between the APB-fed TX data FIFO and the SENT frame encoder in the transmit clock domain.
- Each frame, it pulls one 12-bit fast-channel word from the FIFO, or re-sends the last word if the FIFO is empty.
- It builds the status nibble. Bits 3:2 carry the serial (slow) channel message, streamed one bit pair per frame: 16 frames in short serial format, 18 frames in enhanced format.
- It hands each frame to the encoder with a valid/ready handshake and waits for frame completion.

Parameters:
- DATAWIDTH, 12, fast-channel data word width.
- STATUS_APP, 2'b00, constant placed in status nibble bits 1:0.
- SHORT_LEN, 16, frames per serial message when channel_format=0.
- ENH_LEN, 18, frames per serial message when channel_format=1.

Ports:
- clk_tx  in  1  transmit clock.
- reset_tx  in  1  reset, asynchronous, active-high.
- enable  in  1  run request; frames are issued back-to-back while high.
- channel_format  in  1  0 = short serial, 1 = enhanced serial; sampled only at message load.
- fifo_empty  in  1  TX FIFO empty flag.
- fifo_rd_en  out  1  one-cycle read pulse to the FIFO.
- fifo_rdata  in  DATAWIDTH  FIFO read data, valid the cycle after fifo_rd_en.
- msg_valid  in  1  serial message offered.
- msg_bit2  in  18  serial bit-2 stream; index k is used in frame k.
- msg_bit3  in  18  serial bit-3 stream; index k is used in frame k.
- msg_ready  out  1  a message is accepted when msg_valid&msg_ready at FETCH.
- frame_valid  out  1  frame offered to the encoder.
- enc_ready  in  1  encoder accepts a frame.
- frame_data  out  DATAWIDTH  fast-channel data for the offered frame.
- frame_status  out  4  {serial bit3, serial bit2, STATUS_APP}.
- frame_done  in  1  encoder pulse: frame, including any pause, fully transmitted.
- stale_data  out  1  the offered frame repeats previous data because the FIFO was empty.
- msg_done  out  1  one-cycle pulse after the last frame of a serial message completes.

Behaviour:
- Reset: state=IDLE. All outputs are 0, the last-data register is 0, the serial index is 0 and no message is active.
- IDLE: when enable=1, go to FETCH on the next edge.
- FETCH (1 cycle), fast channel:
  - If the FIFO is not empty: fifo_rd_en=1, then go to WAIT_RD.
  - Else: stale_data=1, keep the last data, then go to ISSUE.
- FETCH (same cycle), serial channel:
  - msg_ready = (no message active).
  - On msg_valid&msg_ready: latch msg_bit2/msg_bit3, set length = channel_format ? ENH_LEN : SHORT_LEN, and set index=0.
- WAIT_RD (1 cycle): capture fifo_rdata into the data register, clear stale_data, then go to ISSUE.
- ISSUE:
  - frame_valid=1. frame_data and frame_status are stable while valid.
  - frame_status[3:2] = message active ? {bit3[idx], bit2[idx]} : 2'b00.
  - Hold until enc_ready=1. On the handshake edge, drop frame_valid and go to WAIT_DONE.
- WAIT_DONE:
  - On frame_done: if a message is active, increment the index.
  - If the index reaches length-1 at that frame_done: pulse msg_done, deactivate the message and reset the index to 0.
  - Then go to FETCH if enable=1, else IDLE.
- Latency from enable rising edge (cycle 0):
  - FIFO non-empty: fifo_rd_en at cycle 1, frame_valid at cycle 3.
  - FIFO empty: frame_valid at cycle 2.
- Minimum gap between frame_done and the next frame_valid is 3 cycles (2 if the FIFO is empty).
- A frame_done outside WAIT_DONE is ignored.
- Enable deasserted mid-frame:
  - The current frame completes normally.
  - On that frame_done the scheduler returns to IDLE and any active serial message is aborted: index=0, message inactive, no msg_done.
- channel_format changes while a message is active take effect only at the next message load.
- Re-enable after IDLE restarts at FETCH. The last-data register is retained, so the first frame may be stale if the FIFO is empty.
- Exactly one FIFO read occurs per issued non-stale frame; the FIFO is never read while it is empty.
- Reset asserted mid-operation clears everything immediately (asynchronously), including frame_valid.

Test Plan:
- Reset, write 0x001 and 0x002 to the FIFO, enable=1, enc_ready=1, frame_done 5 cycles after each handshake -> frames carry data 0x001 then 0x002 with stale_data=0. fifo_rd_en pulses exactly twice. frame_valid first appears at cycle 3.
- FIFO holds only 0x00A, three frames run -> frame data is 0x00A, 0x00A, 0x00A. stale_data=0,1,1. Only one fifo_rd_en pulse.
- channel_format=1, msg_bit3=18'h00001, msg_bit2=18'h2AAAA, 18 frames -> frame k status[3:2] = {bit3[k], bit2[k]}. msg_done pulses once after frame 17. msg_ready returns to 1 at the next FETCH.
- channel_format=0, msg_bit3=18'h00001 -> msg_done after frame 15. A new message is accepted at frame 16 with index 0.
- enc_ready held low for 10 cycles -> frame_valid, frame_data and frame_status stay constant. No further FIFO read occurs.
- enable dropped during frame 5 of an enhanced message -> the frame finishes and the scheduler returns to IDLE without msg_done. On re-enable, the next message starts at index 0.
- reset_tx pulsed while in ISSUE -> frame_valid=0 immediately, state IDLE, all outputs 0.
